// File: rtl/score_bcd_scheduler.sv
// Two-channel binary-to-BCD scheduler: one shared shift-add-3 converter,
// round-robin granted, with clamp or modulo-100 handling of operands above 99.
module score_bcd_scheduler #(
    parameter bit CLAMP_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       req0,
    input  logic [6:0] val0,
    input  logic       req1,
    input  logic [6:0] val1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] tens0,
    output logic [3:0] ones0,
    output logic [3:0] tens1,
    output logic [3:0] ones1,
    output logic       ovf0,
    output logic       ovf1,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e      state_q, state_d;
    logic [14:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [3:0]  tens0_q, tens0_d, ones0_q, ones0_d;
    logic [3:0]  tens1_q, tens1_d, ones1_q, ones1_d;
    logic        ovf0_q, ovf0_d, ovf1_q, ovf1_d;

    logic        pick;
    logic [6:0]  cap_val;
    logic        cap_ovf;
    logic [6:0]  op;
    logic [3:0]  tens_adj, ones_adj;

    // Contention goes to the channel not served last; a lone request always wins.
    assign pick    = (req0 && req1) ? ~last_grant_q : req1;
    assign cap_val = pick ? val1 : val0;
    assign cap_ovf = (cap_val > 7'd99);
    assign op      = cap_ovf ? (CLAMP_EN ? 7'd99 : cap_val - 7'd100) : cap_val;

    assign tens_adj = (sr_q[14:11] >= 4'd5) ? sr_q[14:11] + 4'd3 : sr_q[14:11];
    assign ones_adj = (sr_q[10:7]  >= 4'd5) ? sr_q[10:7]  + 4'd3 : sr_q[10:7];

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ovf_pend_d   = ovf_pend_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tens0_d      = tens0_q;
        ones0_d      = ones0_q;
        tens1_d      = tens1_q;
        ones1_d      = ones1_q;
        ovf0_d       = ovf0_q;
        ovf1_d       = ovf1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    sr_d         = {8'h00, op};
                    cnt_d        = '0;
                    ovf_pend_d   = cap_ovf;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // Tens MSB falling off the top is the hundreds carry, always 0 here.
                sr_d  = {tens_adj[2:0], ones_adj, sr_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (grant_q) begin
                    tens1_d = sr_q[14:11];
                    ones1_d = sr_q[10:7];
                    ovf1_d  = ovf_pend_q;
                    ack1_d  = 1'b1;
                end else begin
                    tens0_d = sr_q[14:11];
                    ones0_d = sr_q[10:7];
                    ovf0_d  = ovf_pend_q;
                    ack0_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ovf_pend_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tens0_q      <= '0;
            ones0_q      <= '0;
            tens1_q      <= '0;
            ones1_q      <= '0;
            ovf0_q       <= 1'b0;
            ovf1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ovf_pend_q   <= ovf_pend_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            tens0_q      <= tens0_d;
            ones0_q      <= ones0_d;
            tens1_q      <= tens1_d;
            ones1_q      <= ones1_d;
            ovf0_q       <= ovf0_d;
            ovf1_q       <= ovf1_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign tens0 = tens0_q;
    assign ones0 = ones0_q;
    assign tens1 = tens1_q;
    assign ones1 = ones1_q;
    assign ovf0  = ovf0_q;
    assign ovf1  = ovf1_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler: a clamping and a modulo instance
// driven in lockstep, checked against hand-computed decimal results.
module tb_score_bcd_scheduler;

    logic       Clk, Reset_n;
    logic       req0, req1;
    logic [6:0] val0, val1;

    logic       ack0_a, ack1_a, ovf0_a, ovf1_a, busy_a;
    logic [3:0] tens0_a, ones0_a, tens1_a, ones1_a;
    logic       ack0_b, ack1_b, ovf0_b, ovf1_b, busy_b;
    logic [3:0] tens0_b, ones0_b, tens1_b, ones1_b;

    int n_cmp = 0;
    int n_bad = 0;

    score_bcd_scheduler #(.CLAMP_EN(1'b1)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req0), .val0(val0), .req1(req1), .val1(val1),
        .ack0(ack0_a), .ack1(ack1_a),
        .tens0(tens0_a), .ones0(ones0_a), .tens1(tens1_a), .ones1(ones1_a),
        .ovf0(ovf0_a), .ovf1(ovf1_a), .busy(busy_a)
    );

    score_bcd_scheduler #(.CLAMP_EN(1'b0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req0), .val0(val0), .req1(req1), .val1(val1),
        .ack0(ack0_b), .ack1(ack1_b),
        .tens0(tens0_b), .ones0(ones0_b), .tens1(tens1_b), .ones1(ones1_b),
        .ovf0(ovf0_b), .ovf1(ovf1_b), .busy(busy_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit         ch;
        logic [6:0] v;
        int         t, o, ov;
        int         tm, om;
    } vec_t;

    vec_t vecs[10];

    // Last written digits per channel, for the clamping (a) and modulo (b) instance
    int mt_a[2], mo_a[2], mv_a[2];
    int mt_b[2], mo_b[2], mv_b[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            mt_a[i] = 0; mo_a[i] = 0; mv_a[i] = 0;
            mt_b[i] = 0; mo_b[i] = 0; mv_b[i] = 0;
        end
    endtask

    // Raise one request for one capture edge, then wait (bounded) for its ack.
    task automatic run_conv(input bit ch, input logic [6:0] v, output int lat);
        @(negedge Clk);
        if (ch) begin req1 = 1'b1; val1 = v; end
        else    begin req0 = 1'b1; val0 = v; end
        @(posedge Clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        check("busy_after_capture", busy_a, 1);
        lat = 0;
        while (lat < 20) begin
            @(posedge Clk); #1;
            lat++;
            if (ch ? ack1_a : ack0_a) break;
        end
        check("ack_b_with_a", ch ? ack1_b : ack0_b, 1);
    endtask

    int lat;
    int cnt;
    int ack0_t[$];
    int ack1_t[$];
    int et, eo, ev, emt, emo;

    initial begin
        Reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0;
        clear_model();

        vecs[0] = '{1'b0, 7'd47,  4, 7, 0, 4, 7};
        vecs[1] = '{1'b1, 7'd99,  9, 9, 0, 9, 9};
        vecs[2] = '{1'b1, 7'd120, 9, 9, 1, 2, 0};
        vecs[3] = '{1'b0, 7'd0,   0, 0, 0, 0, 0};
        vecs[4] = '{1'b0, 7'd100, 9, 9, 1, 0, 0};
        vecs[5] = '{1'b0, 7'd127, 9, 9, 1, 2, 7};
        vecs[6] = '{1'b1, 7'd5,   0, 5, 0, 0, 5};
        vecs[7] = '{1'b1, 7'd100, 9, 9, 1, 0, 0};
        vecs[8] = '{1'b0, 7'd10,  1, 0, 0, 1, 0};
        vecs[9] = '{1'b1, 7'd64,  6, 4, 0, 6, 4};

        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_ack0", ack0_a, 0);
        check("rst_ack1", ack1_a, 0);
        check("rst_digits", {tens0_a, ones0_a, tens1_a, ones1_a}, 0);
        check("rst_ovf", {ovf0_a, ovf1_a}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].ch, vecs[i].v, lat);
            check("latency", lat, 8);
            check("busy_at_ack", busy_a, 0);
            if (vecs[i].ch) begin
                check("tens1", tens1_a, vecs[i].t);
                check("ones1", ones1_a, vecs[i].o);
                check("ovf1", ovf1_a, vecs[i].ov);
                check("tens1_mod", tens1_b, vecs[i].tm);
                check("ones1_mod", ones1_b, vecs[i].om);
                check("ovf1_mod", ovf1_b, vecs[i].ov);
                check("ch0_hold", {tens0_a, ones0_a, 3'b000, ovf0_a}, {mt_a[0][3:0], mo_a[0][3:0], 4'(mv_a[0])});
                check("ch0_hold_mod", {tens0_b, ones0_b, 3'b000, ovf0_b}, {mt_b[0][3:0], mo_b[0][3:0], 4'(mv_b[0])});
                check("no_ack0", ack0_a, 0);
            end else begin
                check("tens0", tens0_a, vecs[i].t);
                check("ones0", ones0_a, vecs[i].o);
                check("ovf0", ovf0_a, vecs[i].ov);
                check("tens0_mod", tens0_b, vecs[i].tm);
                check("ones0_mod", ones0_b, vecs[i].om);
                check("ovf0_mod", ovf0_b, vecs[i].ov);
                check("ch1_hold", {tens1_a, ones1_a, 3'b000, ovf1_a}, {mt_a[1][3:0], mo_a[1][3:0], 4'(mv_a[1])});
                check("ch1_hold_mod", {tens1_b, ones1_b, 3'b000, ovf1_b}, {mt_b[1][3:0], mo_b[1][3:0], 4'(mv_b[1])});
                check("no_ack1", ack1_a, 0);
            end
            mt_a[vecs[i].ch] = vecs[i].t;  mo_a[vecs[i].ch] = vecs[i].o;  mv_a[vecs[i].ch] = vecs[i].ov;
            mt_b[vecs[i].ch] = vecs[i].tm; mo_b[vecs[i].ch] = vecs[i].om; mv_b[vecs[i].ch] = vecs[i].ov;
        end

        // Operand changed mid-conversion, plus a req1 pulse that never reaches IDLE
        @(negedge Clk);
        req0 = 1'b1; val0 = 7'd63;
        @(posedge Clk); #1;
        req0 = 1'b0; val0 = 7'd12;
        @(posedge Clk);
        @(negedge Clk);
        req1 = 1'b1; val1 = 7'd55;
        @(posedge Clk); #1;
        req1 = 1'b0;
        lat = 2;
        while (lat < 20) begin
            @(posedge Clk); #1;
            lat++;
            if (ack0_a) break;
        end
        check("midshift_latency", lat, 8);
        check("midshift_tens0", tens0_a, 6);
        check("midshift_ones0", ones0_a, 3);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk); #1;
            if (ack1_a) cnt++;
        end
        check("dropped_req_no_ack1", cnt, 0);
        check("dropped_req_idle", busy_a, 0);
        check("dropped_req_tens1", tens1_a, mt_a[1]);

        // Reset during the 4th SHIFT cycle of 88
        @(negedge Clk);
        req0 = 1'b1; val0 = 7'd88;
        @(posedge Clk); #1;
        req0 = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_ack0", ack0_a, 0);
        check("abort_digits0", {tens0_a, ones0_a, ovf0_a}, 0);
        check("abort_digits1", {tens1_a, ones1_a, ovf1_a}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        clear_model();
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk); #1;
            if (ack0_a || busy_a) cnt++;
        end
        check("abort_no_ack_no_busy", cnt, 0);
        check("abort_digits_stay0", {tens0_a, ones0_a}, 0);

        // Contention held high: ch0 first after reset, then strict alternation
        @(negedge Clk);
        req0 = 1'b1; val0 = 7'd5; req1 = 1'b1; val1 = 7'd99;
        @(posedge Clk); #1;
        check("contend_busy", busy_a, 1);
        for (int k = 1; k <= 26; k++) begin
            @(posedge Clk); #1;
            check("ack_onehot", {31'd0, ack0_a & ack1_a}, 0);
            if (ack0_a) begin
                ack0_t.push_back(k);
                check("contend_ch0_digits", {tens0_a, ones0_a}, 8'h05);
            end
            if (ack1_a) begin
                ack1_t.push_back(k);
                check("contend_ch1_digits", {tens1_a, ones1_a}, 8'h99);
            end
        end
        @(negedge Clk);
        req0 = 1'b0; req1 = 1'b0;
        check("contend_ack0_count", ack0_t.size(), 2);
        check("contend_ack1_count", ack1_t.size(), 1);
        if (ack0_t.size() == 2) begin
            check("contend_ack0_first", ack0_t[0], 8);
            check("contend_ack0_second", ack0_t[1], 26);
        end
        if (ack1_t.size() == 1)
            check("contend_ack1_time", ack1_t[0], 17);
        repeat (2) @(posedge Clk);
        #1;
        check("contend_idle", busy_a, 0);

        // Full operand sweep on channel 0
        for (int v = 0; v < 128; v++) begin
            et  = (v > 99) ? 9 : v / 10;
            eo  = (v > 99) ? 9 : v % 10;
            ev  = (v > 99) ? 1 : 0;
            emt = ((v > 99) ? v - 100 : v) / 10;
            emo = ((v > 99) ? v - 100 : v) % 10;
            run_conv(1'b0, 7'(v), lat);
            check("sweep_latency", lat, 8);
            check("sweep_a", {tens0_a, ones0_a, 3'b000, ovf0_a}, {et[3:0], eo[3:0], 4'(ev)});
            check("sweep_b", {tens0_b, ones0_b, 3'b000, ovf0_b}, {emt[3:0], emo[3:0], 4'(ev)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
